// File: rtl/bsg_link_ddr_pkg.sv
// Shared DDR link helpers: flit width derivation and parameter legality
// checks used by both the upstream and downstream halves of the link.
package bsg_link_ddr_pkg;

    function automatic int ddr_width(input int channel_width);
        return 2 * channel_width;
    endfunction

    function automatic bit width_legal(input int width, input int ddr_w);
        return (ddr_w > 0) && (width >= ddr_w) && ((width % ddr_w) == 0);
    endfunction

    function automatic bit decimation_legal(input int lg_dec, input int lg_depth);
        return (lg_dec >= 1) && (lg_dec < lg_depth);
    endfunction

endpackage

// File: rtl/bsg_link_sipo_assembler.sv
// Serial-in parallel-out word assembler: first flit lands in the LSBs,
// completed words are presented on a valid/yumi interface.
module bsg_link_sipo_assembler #(
    parameter int width_p     = 32,
    parameter int ddr_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   pop_v_i,
    input  logic [ddr_width_p-1:0] pop_data_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     data_o,
    output logic                   valid_o,
    input  logic                   yumi_i
);

    localparam int sipo_ratio_p = width_p / ddr_width_p;
    localparam int cnt_w_lp     = (sipo_ratio_p > 1) ? $clog2(sipo_ratio_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(sipo_ratio_p - 1);

    logic [sipo_ratio_p-1:0][ddr_width_p-1:0] r_slots;
    logic [cnt_w_lp-1:0]                      r_cnt;
    logic                                     r_valid;

    // A held word may only be overwritten in the cycle it is consumed.
    assign ready_o = ~r_valid | yumi_i;
    assign data_o  = r_slots;
    assign valid_o = r_valid;

    always_ff @(posedge clk_i) begin
        if (pop_v_i) begin
            r_slots[r_cnt] <= pop_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (yumi_i) begin
                r_valid <= 1'b0;
            end
            if (pop_v_i) begin
                if (r_cnt == last_lp) begin
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bsg_link_ddr_downstream_core.sv
// Core-clock receive half of the DDR link: credit-sized flit FIFO,
// word reassembly and decimated credit token return.
module bsg_link_ddr_downstream_core
    import bsg_link_ddr_pkg::*;
#(
    parameter int width_p                         = 32,
    parameter int channel_width_p                 = 8,
    parameter int lg_fifo_depth_p                 = 6,
    parameter int lg_credit_to_token_decimation_p = 3,
    localparam int ddr_width_p = ddr_width(channel_width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   flit_v_i,
    input  logic [ddr_width_p-1:0] flit_data_i,
    output logic [width_p-1:0]     data_o,
    output logic                   valid_o,
    input  logic                   yumi_i,
    output logic                   token_o,
    output logic                   overflow_o
);

    localparam int depth_lp  = 1 << lg_fifo_depth_p;
    localparam int lg_dec_lp = lg_credit_to_token_decimation_p;

    if (!width_legal(width_p, ddr_width_p)) begin : g_bad_width
        $error("width_p must be a nonzero multiple of ddr_width_p");
    end
    if (!decimation_legal(lg_dec_lp, lg_fifo_depth_p)) begin : g_bad_dec
        $error("token decimation must satisfy 1 <= L < lg_fifo_depth_p");
    end

    logic [ddr_width_p-1:0]   r_mem [depth_lp];
    logic [lg_fifo_depth_p:0] r_wptr;
    logic [lg_fifo_depth_p:0] r_rptr;
    logic [lg_dec_lp-1:0]     r_fc;
    logic                     r_token;
    logic                     r_overflow;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_pop;
    logic w_sipo_ready;

    // Extra wrap bit distinguishes full from empty at equal addresses.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[lg_fifo_depth_p-1:0] == r_rptr[lg_fifo_depth_p-1:0])
                   && (r_wptr[lg_fifo_depth_p] != r_rptr[lg_fifo_depth_p]);
    assign w_enq   = flit_v_i & ~w_full;
    assign w_pop   = ~w_empty & w_sipo_ready;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[lg_fifo_depth_p-1:0]] <= flit_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fc       <= '0;
            r_token    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_fc   <= r_fc + 1'b1;
            end
            r_token <= r_fc[lg_dec_lp-1];
            if (flit_v_i && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign token_o    = r_token;
    assign overflow_o = r_overflow;

    bsg_link_sipo_assembler #(
        .width_p     (width_p),
        .ddr_width_p (ddr_width_p)
    ) u_sipo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .pop_v_i    (w_pop),
        .pop_data_i (r_mem[r_rptr[lg_fifo_depth_p-1:0]]),
        .ready_o    (w_sipo_ready),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .yumi_i     (yumi_i)
    );

endmodule
